// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck CPU program loader: opcodes, source
// characters, loader states and error codes.
package bf_pkg;

  localparam logic [2:0] OP_INC   = 3'b111;
  localparam logic [2:0] OP_DEC   = 3'b110;
  localparam logic [2:0] OP_RIGHT = 3'b101;
  localparam logic [2:0] OP_LEFT  = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b011;
  localparam logic [2:0] OP_JNZ   = 3'b010;
  localparam logic [2:0] OP_OUT   = 3'b001;
  localparam logic [2:0] OP_IN    = 3'b000;

  localparam logic [7:0] CH_INC   = 8'h2B;
  localparam logic [7:0] CH_DEC   = 8'h2D;
  localparam logic [7:0] CH_RIGHT = 8'h3E;
  localparam logic [7:0] CH_LEFT  = 8'h3C;
  localparam logic [7:0] CH_JZ    = 8'h5B;
  localparam logic [7:0] CH_JNZ   = 8'h5D;
  localparam logic [7:0] CH_OUT   = 8'h2E;
  localparam logic [7:0] CH_IN    = 8'h2C;
  localparam logic [7:0] CH_NUL   = 8'h00;
  localparam logic [7:0] CH_BANG  = 8'h21;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_UNMATCHED = 2'b01,
    ERR_UNCLOSED  = 2'b10,
    ERR_OVERFLOW  = 2'b11
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } load_state_e;

endpackage

// File: rtl/bf_char_encoder.sv
// Maps one ASCII source byte to a Brainfuck opcode; flags commands and
// program terminators, everything else is a comment.
module bf_char_encoder
  import bf_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       is_cmd_o,
  output logic       is_term_o,
  output logic [2:0] code_o
);

  always_comb begin
    is_cmd_o  = 1'b1;
    is_term_o = 1'b0;
    code_o    = OP_IN;
    unique case (byte_i)
      CH_INC:   code_o = OP_INC;
      CH_DEC:   code_o = OP_DEC;
      CH_RIGHT: code_o = OP_RIGHT;
      CH_LEFT:  code_o = OP_LEFT;
      CH_JZ:    code_o = OP_JZ;
      CH_JNZ:   code_o = OP_JNZ;
      CH_OUT:   code_o = OP_OUT;
      CH_IN:    code_o = OP_IN;
      CH_NUL, CH_BANG: begin
        is_cmd_o  = 1'b0;
        is_term_o = 1'b1;
      end
      default:  is_cmd_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/bf_prog_loader.sv
// Streams Brainfuck source into program RAM as 3-bit opcodes, checking
// bracket balance and capacity, and commits the program length on success.
module bf_prog_loader
  import bf_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DEPTH_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_code,
  output logic [ADDR_W:0]   prog_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W:0]  CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [DEPTH_W-1:0] DEP_ONE = DEPTH_W'(1);

  load_state_e         state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  err_code_e           err_code_q, err_code_d;
  logic [ADDR_W:0]     prog_len_q, prog_len_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [2:0]          wr_code_q, wr_code_d;

  logic       is_cmd, is_term;
  logic [2:0] code;
  logic       full, depth_max, depth_zero;

  bf_char_encoder u_enc (
    .byte_i   (in_data),
    .is_cmd_o (is_cmd),
    .is_term_o(is_term),
    .code_o   (code)
  );

  // The top count bit set means all 2^ADDR_W slots are already written.
  assign full       = count_q[ADDR_W];
  assign depth_max  = &depth_q;
  assign depth_zero = (depth_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      depth_q    <= '0;
      err_code_q <= ERR_NONE;
      prog_len_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_code_q  <= OP_IN;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      depth_q    <= depth_d;
      err_code_q <= err_code_d;
      prog_len_q <= prog_len_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_code_q  <= wr_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    depth_d    = depth_q;
    err_code_d = err_code_q;
    prog_len_d = prog_len_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_code_d  = wr_code_q;
    unique case (state_q)
      ST_LOAD: begin
        if (in_valid && is_term) begin
          if (!depth_zero) begin
            state_d    = ST_ERR;
            err_code_d = ERR_UNCLOSED;
          end else begin
            state_d    = ST_DONE;
            prog_len_d = count_q;
          end
        end else if (in_valid && is_cmd) begin
          // Depth overflow outranks capacity overflow for '['.
          if (code == OP_JZ && depth_max) begin
            state_d    = ST_ERR;
            err_code_d = ERR_OVERFLOW;
          end else if (code == OP_JNZ && depth_zero) begin
            state_d    = ST_ERR;
            err_code_d = ERR_UNMATCHED;
          end else if (full) begin
            state_d    = ST_ERR;
            err_code_d = ERR_OVERFLOW;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = count_q[ADDR_W-1:0];
            wr_code_d = code;
            count_d   = count_q + CNT_ONE;
            if (code == OP_JZ)  depth_d = depth_q + DEP_ONE;
            if (code == OP_JNZ) depth_d = depth_q - DEP_ONE;
          end
        end
      end
      default: begin
        if (start) begin
          state_d    = ST_LOAD;
          count_d    = '0;
          depth_d    = '0;
          err_code_d = ERR_NONE;
          prog_len_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_LOAD);
    busy     = (state_q == ST_LOAD);
    done     = (state_q == ST_DONE);
    err      = (state_q == ST_ERR);
    err_code = err_code_q;
    prog_len = prog_len_q;
    wr_en    = wr_en_q;
    wr_addr  = wr_addr_q;
    wr_code  = wr_code_q;
  end

endmodule

// File: tb/tb_bf_prog_loader.sv
// Bench for bf_prog_loader (small geometry so capacity and nesting limits
// are reachable): string-scanning reference model plus directed scenarios.
module tb_bf_prog_loader;

  localparam int AW   = 3;
  localparam int DW   = 2;
  localparam int CAP  = 8;
  localparam int MAXD = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, wr_en, busy, done, err;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_code;
  logic [AW:0]   prog_len;
  logic [1:0]    err_code;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 idle, 1 load, 2 done, 3 err.
  int         m_phase = 0, m_ec = 0, m_plen = 0, m_waddr = 0, m_wcode = 0;
  bit         m_wen = 1'b0;
  logic [7:0] acc[$];
  int         la[$];
  int         lc[$];

  int exp1_c[5] = '{7, 3, 6, 2, 1};

  bf_prog_loader #(.ADDR_W(AW), .DEPTH_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_code(wr_code), .prog_len(prog_len), .busy(busy), .done(done),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int enc(input logic [7:0] b);
    case (b)
      8'h2B: return 7;
      8'h2D: return 6;
      8'h3E: return 5;
      8'h3C: return 4;
      8'h5B: return 3;
      8'h5D: return 2;
      8'h2E: return 1;
      8'h2C: return 0;
      default: return -1;
    endcase
  endfunction

  // Interpret the whole accepted source text of the current load.
  function automatic void scan(output int st, output int ec, output int cnt);
    int d;
    logic [7:0] b;
    st = 1; ec = 0; cnt = 0; d = 0;
    foreach (acc[i]) begin
      if (st == 1) begin
        b = acc[i];
        if (b == 8'h00 || b == 8'h21) begin
          if (d != 0) begin st = 3; ec = 2; end
          else st = 2;
        end else if (enc(b) >= 0) begin
          if (b == 8'h5B && d == MAXD) begin st = 3; ec = 3; end
          else if (b == 8'h5D && d == 0) begin st = 3; ec = 1; end
          else if (cnt == CAP) begin st = 3; ec = 3; end
          else begin
            cnt++;
            if (b == 8'h5B) d++;
            if (b == 8'h5D) d--;
          end
        end
      end
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_ec = 0; m_plen = 0; m_wen = 1'b0;
        acc.delete();
      end else begin
        m_wen = 1'b0;
        if (m_phase != 1) begin
          if (start) begin
            m_phase = 1; m_ec = 0; m_plen = 0;
            acc.delete();
          end
        end else if (in_valid) begin
          int st0, ec0, c0, st1, ec1, c1;
          scan(st0, ec0, c0);
          acc.push_back(in_data);
          scan(st1, ec1, c1);
          if (c1 > c0) begin
            m_wen = 1'b1; m_waddr = c1 - 1; m_wcode = enc(in_data);
          end
          if (st1 == 2) begin m_phase = 2; m_plen = c1; end
          else if (st1 == 3) begin m_phase = 3; m_ec = ec1; end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", int'(in_ready), int'(m_phase == 1));
      chk("busy",     int'(busy),     int'(m_phase == 1));
      chk("done",     int'(done),     int'(m_phase == 2));
      chk("err",      int'(err),      int'(m_phase == 3));
      chk("err_code", int'(err_code), m_ec);
      chk("prog_len", int'(prog_len), m_plen);
      chk("wr_en",    int'(wr_en),    int'(m_wen));
      if (m_wen) begin
        chk("wr_addr", int'(wr_addr), m_waddr);
        chk("wr_code", int'(wr_code), m_wcode);
      end
      if (wr_en) begin
        la.push_back(int'(wr_addr));
        lc.push_back(int'(wr_code));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic send(input logic [7:0] b, input int gap, input logic st);
    repeat (gap) cyc();
    in_valid = 1'b1; in_data = b; start = st;
    cyc();
    in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send(s[i], gap, 1'b0);
  endtask

  task automatic begin_load();
    start = 1'b1;
    cyc();
    start = 1'b0;
    la.delete(); lc.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " in_ready"}, int'(in_ready), 0);
    chk({tag, " wr_en"},    int'(wr_en),    0);
    chk({tag, " wr_addr"},  int'(wr_addr),  0);
    chk({tag, " wr_code"},  int'(wr_code),  0);
    chk({tag, " prog_len"}, int'(prog_len), 0);
    chk({tag, " busy"},     int'(busy),     0);
    chk({tag, " done"},     int'(done),     0);
    chk({tag, " err"},      int'(err),      0);
    chk({tag, " err_code"}, int'(err_code), 0);
  endtask

  function automatic logic [7:0] rnd_byte();
    int r;
    logic [7:0] b;
    r = $urandom_range(0, 99);
    if (r < 72) begin
      case ($urandom_range(0, 7))
        0: b = 8'h2B; 1: b = 8'h2D; 2: b = 8'h3E; 3: b = 8'h3C;
        4: b = 8'h5B; 5: b = 8'h5D; 6: b = 8'h2E; default: b = 8'h2C;
      endcase
    end else if (r < 97) begin
      b = 8'($urandom_range(1, 255));
    end else begin
      b = ($urandom_range(0, 1) == 1) ? 8'h21 : 8'h00;
    end
    return b;
  endfunction

  initial begin
    int n;
    #3;
    chk_reset_outputs("reset");
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Basic program with NUL terminator.
    begin_load();
    send_str("+[-].", 0);
    send(8'h00, 0, 1'b0);
    idle(1);
    chk("t1 writes", la.size(), 5);
    for (int i = 0; i < 5 && i < la.size(); i++) begin
      chk("t1 addr", la[i], i);
      chk("t1 code", lc[i], exp1_c[i]);
    end
    chk("t1 done", int'(done), 1);
    chk("t1 prog_len", int'(prog_len), 5);
    chk("t1 err_code", int'(err_code), 0);

    // Comments dropped, gaps in in_valid, start ignored while loading.
    begin_load();
    send_str("a+ b", 2);
    send(8'h0A, 1, 1'b1);
    send(8'h2D, 1, 1'b0);
    send(8'h21, 2, 1'b0);
    idle(1);
    chk("t2 writes", la.size(), 2);
    if (la.size() == 2) begin
      chk("t2 code0", lc[0], 7);
      chk("t2 code1", lc[1], 6);
    end
    chk("t2 prog_len", int'(prog_len), 2);
    chk("t2 in_ready", int'(in_ready), 0);

    // Unmatched close bracket; subsequent bytes refused.
    begin_load();
    send(8'h5D, 0, 1'b0);
    chk("t3 err", int'(err), 1);
    chk("t3 err_code", int'(err_code), 1);
    send_str("++[", 0);
    chk("t3 writes", la.size(), 0);
    chk("t3 prog_len", int'(prog_len), 0);

    // Unclosed bracket at end.
    begin_load();
    send_str("[[+]", 0);
    send(8'h00, 0, 1'b0);
    idle(1);
    chk("t4 writes", la.size(), 4);
    chk("t4 err_code", int'(err_code), 2);
    chk("t4 prog_len", int'(prog_len), 0);

    // Capacity overflow then a fresh successful load.
    begin_load();
    send_str("+++++++++", 0);
    idle(1);
    chk("t5 writes", la.size(), 8);
    if (la.size() == 8) chk("t5 last addr", la[7], 7);
    chk("t5 err_code", int'(err_code), 3);
    begin_load();
    send(8'h2B, 0, 1'b0);
    send(8'h00, 0, 1'b0);
    chk("t5b prog_len", int'(prog_len), 1);
    chk("t5b done", int'(done), 1);

    // Nesting overflow takes priority.
    begin_load();
    send_str("[[[[", 0);
    idle(1);
    chk("t6 writes", la.size(), 3);
    chk("t6 err_code", int'(err_code), 3);

    // Asynchronous reset mid-load with a write pending.
    begin_load();
    send_str("++", 0);
    in_valid = 1'b1; in_data = 8'h2B;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    in_valid = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    begin_load();
    send_str(">.", 0);
    send(8'h21, 0, 1'b0);
    idle(1);
    chk("t7 writes", la.size(), 2);
    if (la.size() == 2) begin
      chk("t7 code0", lc[0], 5);
      chk("t7 code1", lc[1], 1);
    end
    chk("t7 prog_len", int'(prog_len), 2);

    // Randomized programs against the reference model.
    for (int t = 0; t < 60; t++) begin
      n = $urandom_range(0, 14);
      begin_load();
      for (int i = 0; i < n; i++)
        send(rnd_byte(), $urandom_range(0, 2), ($urandom_range(0, 19) == 0));
      send(($urandom_range(0, 1) == 1) ? 8'h21 : 8'h00, 0, 1'b0);
      idle($urandom_range(1, 3));
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bf_prog_loader.md
# bf_prog_loader

Program loader for the Brainfuck CPU: accepts a byte stream of Brainfuck source text (e.g. from the UART receiver) and encodes each command character into the CPU's 3-bit opcode. It writes the opcodes sequentially into program RAM and discards comment characters. It checks bracket balance and capacity, then reports the final program length, which the fetch side uses as its overrun bound. It sits between the host byte link and the program memory that the CPU fetch stage reads.

## Interface
- `ADDR_W`, 10, program memory address width; capacity is 2^ADDR_W opcodes
- `DEPTH_W`, 8, bracket nesting counter width
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse; begins a new load; honoured only in IDLE, DONE or ERR
- `in_valid`  in  1  source byte valid
- `in_ready`  out  1  loader can accept a byte; high only in LOAD
- `in_data`  in  8  ASCII source byte
- `wr_en`  out  1  program RAM write strobe
- `wr_addr`  out  ADDR_W  program RAM write address
- `wr_code`  out  3  opcode to write
- `prog_len`  out  ADDR_W+1  committed program length; 0 until a load completes successfully
- `busy`  out  1  high in LOAD
- `done`  out  1  high in DONE (sticky)
- `err`  out  1  high in ERR (sticky)
- `err_code`  out  2  00 none, 01 unmatched `]`, 10 unclosed `[` at end, 11 capacity or depth overflow

## Operation
- Encoding: `+`(0x2B)→111, `-`(0x2D)→110, `>`(0x3E)→101, `<`(0x3C)→100, `[`(0x5B)→011, `]`(0x5D)→010, `.`(0x2E)→001, `,`(0x2C)→000.
- Terminators: 0x00 and `!`(0x21) end the program. All other bytes are comments: they are accepted and dropped, with no write and no counter change.
- FSM states: IDLE, LOAD, DONE, ERR.
  - IDLE/DONE/ERR → LOAD on `start`. Entering LOAD clears `count` (ADDR_W+1 bits), `depth`, `err_code`, `done`, `err` and `prog_len`.
  - LOAD, accepted command byte:
    - `[` increments `depth`; if `depth` is already all-ones → ERR/11, no write.
    - `]` when `depth`==0 → ERR/01, no write; otherwise decrements `depth`.
    - If `count`==2^ADDR_W → ERR/11, no write.
    - Otherwise write the opcode at `wr_addr`=`count`[ADDR_W-1:0], then `count`++.
  - LOAD, accepted terminator: `depth`≠0 → ERR/10; otherwise → DONE with `prog_len`←`count`.
- Overflow precedence for `[`: the depth check comes first, then capacity.
- In ERR, `prog_len` stays 0, so the CPU sees the whole program as overrun.
- `start` asserted during LOAD is ignored.
- An empty program (terminator first) → DONE with `prog_len`=0.

## Timing
- Byte accepted on a rising edge with `in_valid`&&`in_ready`. `in_ready` is a registered function of state: high throughout LOAD, including the cycle the terminator is accepted, and low from the next cycle on.
- Throughput: one byte per cycle; `in_valid` gaps are allowed.
- Write latency: `wr_en`, `wr_addr` and `wr_code` are registered and asserted in the cycle after acceptance, for exactly one cycle per command.
- `done`/`err`/`err_code`/`prog_len` become valid the cycle after the terminating or erroring byte is accepted.
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_code`=000, `prog_len`=0, `busy`=0, `done`=0, `err`=0, `err_code`=00; state IDLE.
- Reset mid-load aborts immediately. A `wr_en` pending for that cycle is dropped, and RAM contents are undefined for the loader.

## Structure
- Package `bf_pkg`:
  - opcode constants (INC..IN, 3-bit)
  - ASCII command and terminator constants
  - `err_code` enum
  - loader state enum
- Sub-module `bf_char_encoder`: combinational; byte → {is_cmd, is_term, code}. It is reusable by a future disassembler/monitor.
- Top level holds the FSM, counters and output registers.

## Test plan
- Load `+[-].` then 0x00 → five writes at addr 0..4, codes 111,011,110,010,001; `done`=1, `prog_len`=5, `err_code`=00.
- Load `a+ b\n-!` with `in_valid` gaps → writes addr0=111 and addr1=110 only; `prog_len`=2; `in_ready` low after `!`.
- Load `]` → no write; next cycle `err`=1, `err_code`=01, `prog_len`=0; later bytes are not accepted.
- Load `[[+]` then 0x00 → 4 writes; `err_code`=10, `prog_len`=0.
- Capacity test with `ADDR_W`=3: nine `+` → 8 writes (addr 0..7); 9th byte → `err_code`=11. A following `start` plus `+`,0x00 → `prog_len`=1.
- Assert `rst_n` low mid-load → all outputs at reset values asynchronously. Then `start` and `>.`,`!` → writes 101,001; `prog_len`=2.
